fir_blk_sched: RTL and testbench

- Block scheduler for the 4-tap polyphase FIR output stage.
- Collects a block of 6 serial input samples, then time-multiplexes one shared 4-multiplier, 2-stage-pipelined MAC over the 6 output phases, one per cycle.
- Keeps the last 3 samples of each block as history for the next block.
- Sits between the sample source and the DWT output packer; coefficients are loaded through a small register port.

---
 rtl/fir_blk_sched.sv | 207 ++++++++++++++++++++
 tb/tb_fir_blk_sched.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_blk_sched.sv
// fir_blk_sched: block scheduler for the 4-tap polyphase FIR output stage.
// Collects 6 serial samples, then issues the 6 output phases (one per cycle)
// to a shared 4-multiplier MAC with a 2-stage pipeline. The last 3 samples
// of each block are kept as history for the next one.
// Optional build macro FIR_SAT_EN: saturate out_data instead of wrapping.
module fir_blk_sched #(
    parameter int W_IN  = 7,
    parameter int C_IN  = 5,
    parameter int Y_OUT = 20,
    parameter int BLK   = 6
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [W_IN-1:0]  in_data,
    input  logic                    coef_wr,
    input  logic [1:0]              coef_addr,
    input  logic signed [C_IN-1:0]  coef_data,
    output logic                    coef_err,
    input  logic                    flush,
    output logic                    out_valid,
    output logic signed [Y_OUT-1:0] out_data,
    output logic                    out_last,
    output logic                    busy
);

    localparam int PROD_W = W_IN + C_IN;
    localparam int SUM_W  = PROD_W + 2;
    localparam int EXT_W  = SUM_W + Y_OUT;
    localparam logic [2:0] CNT_LAST = 3'(BLK - 1);

    typedef enum logic {
        LOAD = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t                  state;
    logic [2:0]              cnt;
    logic [2:0]              phase;
    logic signed [W_IN-1:0]  samp [0:BLK-1];
    logic signed [W_IN-1:0]  hist [0:2];
    logic signed [C_IN-1:0]  coef [0:3];

    logic signed [W_IN-1:0]  x0, x1, x2, x3;
    logic signed [PROD_W-1:0] prod3, prod2, prod1, prod0;
    logic signed [SUM_W-1:0] sum1, sum2;

    logic signed [SUM_W-1:0] sum_p1;
    logic signed [W_IN-1:0]  x1_p1, x0_p1;
    logic signed [C_IN-1:0]  c1_p1, c0_p1;
    logic                    vld_p1;
    logic                    last_p1;

    // Map a full-precision sum onto the output width (wrap or saturate).
    function automatic logic signed [Y_OUT-1:0] fit_out(input logic signed [SUM_W-1:0] s);
        logic signed [EXT_W-1:0] e;
`ifdef FIR_SAT_EN
        logic signed [EXT_W-1:0] hi;
        logic signed [EXT_W-1:0] lo;
`endif
        e = EXT_W'(s);
`ifdef FIR_SAT_EN
        hi = (EXT_W'(1) <<< (Y_OUT - 1)) - EXT_W'(1);
        lo = ~hi;
        if (e > hi) begin
            e = hi;
        end else if (e < lo) begin
            e = lo;
        end
`endif
        return e[Y_OUT-1:0];
    endfunction

    assign busy = (state == CALC) | vld_p1 | out_valid;

    // Block sequencing: sample capture in LOAD, phase stepping in CALC, flush abort.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= LOAD;
            cnt      <= '0;
            phase    <= '0;
            in_ready <= 1'b0;
            for (int i = 0; i < BLK; i++) samp[i] <= '0;
            for (int i = 0; i < 3; i++) hist[i] <= '0;
        end else if (flush) begin
            state    <= LOAD;
            cnt      <= '0;
            phase    <= '0;
            in_ready <= 1'b1;
            for (int i = 0; i < 3; i++) hist[i] <= '0;
        end else begin
            case (state)
                LOAD: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        samp[cnt] <= in_data;
                        if (cnt == CNT_LAST) begin
                            cnt      <= '0;
                            phase    <= '0;
                            state    <= CALC;
                            in_ready <= 1'b0;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                CALC: begin
                    if (phase == CNT_LAST) begin
                        // Newest sample becomes x[n-1] for the next block.
                        hist[0]  <= samp[5];
                        hist[1]  <= samp[4];
                        hist[2]  <= samp[3];
                        phase    <= '0;
                        state    <= LOAD;
                        in_ready <= 1'b1;
                    end else begin
                        phase <= phase + 3'd1;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // Coefficient port: writes land only when idle at a block boundary.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 4; i++) coef[i] <= '0;
            coef_err <= 1'b0;
        end else begin
            coef_err <= 1'b0;
            if (coef_wr) begin
                if (!busy && cnt == 3'd0) begin
                    coef[coef_addr] <= coef_data;
                end else begin
                    coef_err <= 1'b1;
                end
            end
        end
    end

    // Operand selection for phase p: x[p], x[p-1], x[p-2], x[p-3].
    always_comb begin
        x0 = samp[0];
        x1 = hist[0];
        x2 = hist[1];
        x3 = hist[2];
        case (phase)
            3'd0: begin x0 = samp[0]; x1 = hist[0]; x2 = hist[1]; x3 = hist[2]; end
            3'd1: begin x0 = samp[1]; x1 = samp[0]; x2 = hist[0]; x3 = hist[1]; end
            3'd2: begin x0 = samp[2]; x1 = samp[1]; x2 = samp[0]; x3 = hist[0]; end
            3'd3: begin x0 = samp[3]; x1 = samp[2]; x2 = samp[1]; x3 = samp[0]; end
            3'd4: begin x0 = samp[4]; x1 = samp[3]; x2 = samp[2]; x3 = samp[1]; end
            default: begin x0 = samp[5]; x1 = samp[4]; x2 = samp[3]; x3 = samp[2]; end
        endcase
    end

    // Stage 1 arithmetic: outer taps c3*x3 + c2*x2.
    always_comb begin
        prod3 = PROD_W'(x3) * PROD_W'(coef[3]);
        prod2 = PROD_W'(x2) * PROD_W'(coef[2]);
        sum1  = SUM_W'(prod3) + SUM_W'(prod2);
    end

    // ---- stage 1 boundary: partial sum plus delayed inner-tap operands ----
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sum_p1  <= '0;
            x1_p1   <= '0;
            x0_p1   <= '0;
            c1_p1   <= '0;
            c0_p1   <= '0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else begin
            sum_p1  <= sum1;
            x1_p1   <= x1;
            x0_p1   <= x0;
            c1_p1   <= coef[1];
            c0_p1   <= coef[0];
            vld_p1  <= (state == CALC) && !flush;
            last_p1 <= (state == CALC) && (phase == CNT_LAST) && !flush;
        end
    end

    // Stage 2 arithmetic: add inner taps c1*x1 + c0*x0.
    always_comb begin
        prod1 = PROD_W'(x1_p1) * PROD_W'(c1_p1);
        prod0 = PROD_W'(x0_p1) * PROD_W'(c0_p1);
        sum2  = sum_p1 + SUM_W'(prod1) + SUM_W'(prod0);
    end

    // ---- stage 2 boundary: registered output sample ----
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= vld_p1 && !flush;
            out_last  <= vld_p1 && last_p1 && !flush;
            out_data  <= fit_out(sum2);
        end
    end

endmodule

// File: tb/tb_fir_blk_sched.sv
// tb_fir_blk_sched: directed bench for fir_blk_sched with a scoreboard.
// A behavioural FIR model pushes expected outputs when a block is queued;
// a negedge monitor pops and compares every out_valid pulse.
module tb_fir_blk_sched;

    localparam int W_IN  = 7;
    localparam int C_IN  = 5;
    localparam int Y_OUT = 20;

    logic                    clk;
    logic                    rstn;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [W_IN-1:0]  in_data;
    logic                    coef_wr;
    logic [1:0]              coef_addr;
    logic signed [C_IN-1:0]  coef_data;
    logic                    coef_err;
    logic                    flush;
    logic                    out_valid;
    logic signed [Y_OUT-1:0] out_data;
    logic                    out_last;
    logic                    busy;

    fir_blk_sched #(.W_IN(W_IN), .C_IN(C_IN), .Y_OUT(Y_OUT), .BLK(6)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .coef_wr  (coef_wr),
        .coef_addr(coef_addr),
        .coef_data(coef_data),
        .coef_err (coef_err),
        .flush    (flush),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int data;
        bit last;
    } exp_t;

    exp_t q[$];
    int   stream[$];
    int   tests = 0;
    int   fails = 0;
    int   m_coef[4];
    int   m_hist[3];
    int   low_cycles;
    int   blk[6];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic int fit(input int v);
        logic signed [Y_OUT-1:0] t;
        int r;
        r = v;
`ifdef FIR_SAT_EN
        if (r > (1 <<< (Y_OUT - 1)) - 1) r = (1 <<< (Y_OUT - 1)) - 1;
        if (r < -(1 <<< (Y_OUT - 1))) r = -(1 <<< (Y_OUT - 1));
`endif
        t = r[Y_OUT-1:0];
        return int'(t);
    endfunction

    // Reference model: push the first n outputs of a block, roll history on full blocks.
    task automatic push_block(input int xs[6], input int n);
        int y, xi, idx;
        exp_t e;
        for (int p = 0; p < 6; p++) begin
            y = 0;
            for (int k = 0; k < 4; k++) begin
                idx = p - k;
                xi = (idx >= 0) ? xs[idx] : m_hist[-idx - 1];
                y += m_coef[k] * xi;
            end
            if (p < n) begin
                e.data = fit(y);
                e.last = (p == 5);
                q.push_back(e);
            end
        end
        if (n == 6) begin
            m_hist[0] = xs[5];
            m_hist[1] = xs[4];
            m_hist[2] = xs[3];
        end
        for (int i = 0; i < 6; i++) stream.push_back(xs[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive queued samples with in_valid held high, honouring in_ready.
    task automatic feed_stream();
        int i, budget, total;
        i = 0;
        budget = 0;
        low_cycles = 0;
        total = stream.size();
        in_valid = 1'b1;
        while (i < total && budget < 500) begin
            in_data = W_IN'(stream[i]);
            if (in_ready) i++;
            else low_cycles++;
            tick();
            budget++;
        end
        in_valid = 1'b0;
        chk("feed_done", 32'(i), 32'(total));
        stream.delete();
    endtask

    task automatic write_coef(input int addr, input int val, input bit exp_err);
        coef_wr   = 1'b1;
        coef_addr = 2'(addr);
        coef_data = C_IN'(val);
        tick();
        coef_wr = 1'b0;
        chk("coef_err", 32'(coef_err), 32'(exp_err));
        if (!exp_err) m_coef[addr] = val;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk("idle", 32'(busy), 32'd0);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) m_hist[i] = 0;
    endtask

    // Scoreboard monitor: every output pulse must match the next expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rstn && out_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                e = q.pop_front();
                chk("out_data", 32'(out_data), 32'(e.data));
                chk("out_last", 32'(out_last), 32'(e.last));
            end
        end
    end

    initial begin
        rstn = 1'b0; in_valid = 1'b0; in_data = '0; coef_wr = 1'b0;
        coef_addr = '0; coef_data = '0; flush = 1'b0;
        for (int i = 0; i < 4; i++) m_coef[i] = 0;
        for (int i = 0; i < 3; i++) m_hist[i] = 0;

        // Reset state
        repeat (3) tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_coef_err", 32'(coef_err), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        rstn = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Block 1: c = 1,2,3,4, x = 1..6 with pipeline timing checks
        write_coef(0, 1, 1'b0);
        write_coef(1, 2, 1'b0);
        write_coef(2, 3, 1'b0);
        write_coef(3, 4, 1'b0);
        blk = '{1, 2, 3, 4, 5, 6};
        push_block(blk, 6);
        feed_stream();
        chk("calc_in_ready", 32'(in_ready), 32'd0);
        chk("calc_busy", 32'(busy), 32'd1);
        tick();
        chk("lat_t1_valid", 32'(out_valid), 32'd0);
        tick();
        chk("lat_t2_valid", 32'(out_valid), 32'd1);
        repeat (3) tick();
        chk("t5_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        chk("t6_busy", 32'(busy), 32'd1);
        tick();
        chk("t7_out_last", 32'(out_last), 32'd1);
        chk("t7_busy", 32'(busy), 32'd1);
        tick();
        chk("t8_out_valid", 32'(out_valid), 32'd0);
        chk("t8_busy", 32'(busy), 32'd0);

        // Block 2: zeros, outputs come only from history
        blk = '{0, 0, 0, 0, 0, 0};
        push_block(blk, 6);
        feed_stream();
        wait_idle();

        // Back-to-back: 12 samples with in_valid held high
        blk = '{3, -2, 7, -8, 0, 5};
        push_block(blk, 6);
        blk = '{-64, 63, 1, -1, 10, -10};
        push_block(blk, 6);
        feed_stream();
        chk("b2b_ready_low", 32'(low_cycles), 32'd6);
        wait_idle();

        // Coefficient write during CALC is dropped
        blk = '{2, 4, 6, 8, 10, 12};
        push_block(blk, 6);
        feed_stream();
        write_coef(0, 9, 1'b1);
        tick();
        chk("coef_err_pulse_end", 32'(coef_err), 32'd0);
        wait_idle();
        blk = '{1, 1, 1, 1, 1, 1};
        push_block(blk, 6);
        feed_stream();
        wait_idle();

        // Flush at phase 2: only phase 0 result escapes
        blk = '{5, 5, 5, 5, 5, 5};
        push_block(blk, 1);
        feed_stream();
        repeat (2) tick();
        in_valid = 1'b1;
        in_data = W_IN'(3);
        do_flush();
        in_valid = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        repeat (4) tick();
        chk("flush_sb_empty", 32'(q.size()), 32'd0);
        blk = '{1, 2, 3, 4, 5, 6};
        push_block(blk, 6);
        feed_stream();
        wait_idle();

        // Extreme operands: c = -16, x = -64
        do_flush();
        for (int k = 0; k < 4; k++) write_coef(k, -16, 1'b0);
        blk = '{-64, -64, -64, -64, -64, -64};
        push_block(blk, 6);
        feed_stream();
        wait_idle();

        repeat (5) tick();
        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
